// File: rtl/master_writeback_control.sv
// Skewed write-address sequencer: lane j writes rows base..base+num_row, lagging lane 0 by j cycles,
// so stores line up with the diagonal wavefront leaving the bottom edge of the systolic array.
module master_writeback_control #(
    parameter int addr_width   = 8,
    parameter int width_height = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               active,
    input  logic [addr_width-1:0]              base_addr,
    input  logic [$clog2(width_height)-1:0]    num_row,
    input  logic [$clog2(width_height)-1:0]    num_col,
    input  logic                               data_valid,
    output logic [addr_width*width_height-1:0] out_addr,
    output logic [width_height-1:0]            out_wr_en,
    output logic                               busy,
    output logic                               done
);

    localparam int CW = $clog2(width_height);
    localparam int KW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [KW-1:0]                        k_q, k_d;
    logic [addr_width-1:0]                base_q, base_d;
    logic [CW-1:0]                        num_row_q, num_row_d;
    logic [CW-1:0]                        num_col_q, num_col_d;
    logic [addr_width*width_height-1:0]   out_addr_q, out_addr_d;
    logic [width_height-1:0]              out_wr_en_q, out_wr_en_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 load_s;
    logic [KW-1:0]                        step_s;
    logic [KW-1:0]                        last_s;

    // Last step index is num_row+num_col; one extra bit keeps the max case from overflowing.
    assign last_s = {1'b0, num_row_q} + {1'b0, num_col_q};

    // Next-state, latching and per-lane output decode for the step about to be presented.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        num_row_d   = num_row_q;
        num_col_d   = num_col_q;
        busy_d      = busy_q;
        done_d      = done_q;
        load_s      = 1'b0;
        step_s      = {KW{1'b0}};
        out_addr_d  = {(addr_width*width_height){1'b0}};
        out_wr_en_d = {width_height{1'b0}};

        case (state_q)
            IDLE, DONE: begin
                if (active) begin
                    state_d   = WAIT;
                    base_d    = base_addr;
                    num_row_d = num_row;
                    num_col_d = num_col;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            WAIT: begin
                if (data_valid) begin
                    state_d = WRITE;
                    k_d     = {KW{1'b0}};
                    step_s  = {KW{1'b0}};
                    load_s  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WRITE: begin
                if (k_q == last_s) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d    = k_q + {{(KW-1){1'b0}}, 1'b1};
                    step_s = k_q + {{(KW-1){1'b0}}, 1'b1};
                    load_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Lane j at step k holds row k-j when that row and column are inside the requested tile.
        for (int j = 0; j < width_height; j++) begin
            if (load_s && (KW'(j) <= {1'b0, num_col_q}) && (step_s >= KW'(j)) &&
                ((step_s - KW'(j)) <= {1'b0, num_row_q})) begin
                out_wr_en_d[j]                         = 1'b1;
                out_addr_d[j*addr_width +: addr_width] = base_q + addr_width'(step_s - KW'(j));
            end else begin
                out_wr_en_d[j]                         = 1'b0;
                out_addr_d[j*addr_width +: addr_width] = {addr_width{1'b0}};
            end
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= {KW{1'b0}};
            base_q      <= {addr_width{1'b0}};
            num_row_q   <= {CW{1'b0}};
            num_col_q   <= {CW{1'b0}};
            out_addr_q  <= {(addr_width*width_height){1'b0}};
            out_wr_en_q <= {width_height{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            num_row_q   <= num_row_d;
            num_col_q   <= num_col_d;
            out_addr_q  <= out_addr_d;
            out_wr_en_q <= out_wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_addr  = out_addr_q;
    assign out_wr_en = out_wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_master_writeback_control.sv
// Directed bench for master_writeback_control: skewed write windows, wrap, max tile, ignored inputs, reset.
module tb_master_writeback_control;

    logic         clk = 1'b0;
    logic         reset;
    logic         active;
    logic [7:0]   base_addr;
    logic [3:0]   num_row;
    logic [3:0]   num_col;
    logic         data_valid;
    logic [127:0] out_addr;
    logic [15:0]  out_wr_en;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    master_writeback_control #(.addr_width(8), .width_height(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .active     (active),
        .base_addr  (base_addr),
        .num_row    (num_row),
        .num_col    (num_col),
        .data_valid (data_valid),
        .out_addr   (out_addr),
        .out_wr_en  (out_wr_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: lane j at step k carries row r = k - j when inside the tile.
    function automatic logic [15:0] exp_en(input int k, input int nr, input int nc);
        logic [15:0] e = 16'h0000;
        for (int j = 0; j < 16; j++) begin
            if (j <= nc && (k - j) >= 0 && (k - j) <= nr) e[j] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [127:0] exp_addr(input int k, input int b, input int nr, input int nc);
        logic [127:0] a = 128'h0;
        for (int j = 0; j < 16; j++) begin
            if (j <= nc && (k - j) >= 0 && (k - j) <= nr) a[j*8 +: 8] = 8'(b + k - j);
        end
        return a;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [7:0] b, input logic [3:0] r, input logic [3:0] c);
        base_addr = b;
        num_row   = r;
        num_col   = c;
        active    = 1'b1;
        cyc();
        active    = 1'b0;
    endtask

    task automatic fire();
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; active = 1'b0; data_valid = 1'b0;
        base_addr = 8'h00; num_row = 4'd0; num_col = 4'd0;
        cyc(); cyc();
        reset = 1'b0;
        n_tests++;
        if (out_addr !== 128'h0 || out_wr_en !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: addr=%h en=%h busy=%b done=%b, want all zero", out_addr, out_wr_en, busy, done);
        end
    endtask

    task automatic test_diagonal();
        int writes = 0;
        logic [7:0] lane2;
        arm(8'h10, 4'd3, 4'd3);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0 || out_wr_en !== 16'h0) begin
            n_fail++;
            $display("FAIL diag_arm: busy=%b done=%b en=%h, want 1 0 0000", busy, done, out_wr_en);
        end
        cyc();
        fire();
        for (int k = 0; k <= 6; k++) begin
            n_tests++;
            if (out_wr_en !== exp_en(k, 3, 3) || out_addr !== exp_addr(k, 8'h10, 3, 3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL diag_k%0d: en=%h addr=%h busy=%b, want en=%h addr=%h busy=1", k, out_wr_en, out_addr,
                         busy, exp_en(k, 3, 3), exp_addr(k, 8'h10, 3, 3));
            end
            if (k >= 2 && k <= 5) begin
                lane2 = 8'h10 + 8'(k - 2);
                n_tests++;
                if (out_wr_en[2] !== 1'b1 || out_addr[23:16] !== lane2) begin
                    n_fail++;
                    $display("FAIL diag_lane2_k%0d: en=%b addr=%h, want 1 %h", k, out_wr_en[2], out_addr[23:16], lane2);
                end
            end
            writes += $countones(out_wr_en);
            cyc();
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || out_wr_en !== 16'h0 || writes != 16) begin
            n_fail++;
            $display("FAIL diag_end: done=%b busy=%b en=%h writes=%0d, want 1 0 0000 16", done, busy, out_wr_en, writes);
        end
    endtask

    task automatic test_single();
        arm(8'h05, 4'd0, 4'd0);
        fire();
        n_tests++;
        if (out_wr_en !== 16'h0001 || out_addr !== 128'h05) begin
            n_fail++;
            $display("FAIL single_write: en=%h addr=%h, want 0001 ..05", out_wr_en, out_addr);
        end
        cyc();
        n_tests++;
        if (done !== 1'b1 || out_wr_en !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b en=%h busy=%b, want 1 0000 0", done, out_wr_en, busy);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] tbl [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        arm(8'hFE, 4'd3, 4'd0);
        fire();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_wr_en !== 16'h0001 || out_addr[7:0] !== tbl[i] || out_addr[127:8] !== 120'h0) begin
                n_fail++;
                $display("FAIL wrap_%0d: en=%h lane0=%h, want 0001 %h", i, out_wr_en, out_addr[7:0], tbl[i]);
            end
            cyc();
        end
        n_tests++;
        if (done !== 1'b1 || out_wr_en !== 16'h0) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b en=%h, want 1 0000", done, out_wr_en);
        end
    endtask

    task automatic test_max();
        int writes = 0;
        arm(8'h20, 4'd15, 4'd15);
        fire();
        for (int k = 0; k <= 30; k++) begin
            n_tests++;
            if (out_wr_en !== exp_en(k, 15, 15) || out_addr !== exp_addr(k, 8'h20, 15, 15) ||
                out_wr_en[15] !== (k >= 15)) begin
                n_fail++;
                $display("FAIL max_k%0d: en=%h addr=%h, want en=%h addr=%h", k, out_wr_en, out_addr,
                         exp_en(k, 15, 15), exp_addr(k, 8'h20, 15, 15));
            end
            writes += $countones(out_wr_en);
            cyc();
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || out_wr_en !== 16'h0 || writes != 256) begin
            n_fail++;
            $display("FAIL max_end: done=%b busy=%b en=%h writes=%0d, want 1 0 0000 256", done, busy, out_wr_en, writes);
        end
    endtask

    task automatic test_ignore();
        arm(8'h40, 4'd2, 4'd1);
        fire();
        for (int k = 0; k <= 3; k++) begin
            n_tests++;
            if (out_wr_en !== exp_en(k, 2, 1) || out_addr !== exp_addr(k, 8'h40, 2, 1)) begin
                n_fail++;
                $display("FAIL ignore_k%0d: en=%h addr=%h, want en=%h addr=%h", k, out_wr_en, out_addr,
                         exp_en(k, 2, 1), exp_addr(k, 8'h40, 2, 1));
            end
            if (k == 1) begin
                base_addr = 8'h80; num_row = 4'd0; num_col = 4'd0; active = 1'b1;
            end
            cyc();
            active = 1'b0;
        end
        fire();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_wr_en !== 16'h0 || done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_dv_done_%0d: en=%h done=%b busy=%b, want 0000 1 0", i, out_wr_en, done, busy);
            end
            cyc();
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        fire();
        cyc();
        n_tests++;
        if (out_wr_en !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_dv_idle: en=%h busy=%b done=%b, want 0000 0 0", out_wr_en, busy, done);
        end
    endtask

    task automatic test_reset_mid();
        arm(8'h10, 4'd3, 4'd3);
        cyc();
        fire();
        for (int k = 0; k <= 4; k++) begin
            n_tests++;
            if (out_wr_en !== exp_en(k, 3, 3) || out_addr !== exp_addr(k, 8'h10, 3, 3)) begin
                n_fail++;
                $display("FAIL rmid_k%0d: en=%h addr=%h, want en=%h addr=%h", k, out_wr_en, out_addr,
                         exp_en(k, 3, 3), exp_addr(k, 8'h10, 3, 3));
            end
            if (k < 4) cyc();
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_tests++;
        if (out_wr_en !== 16'h0 || out_addr !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_reset: en=%h addr=%h busy=%b done=%b, want all zero", out_wr_en, out_addr, busy, done);
        end
        cyc(); cyc();
        n_tests++;
        if (out_wr_en !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_no_resume: en=%h busy=%b, want 0000 0", out_wr_en, busy);
        end
        reset = 1'b1; active = 1'b1; base_addr = 8'h33;
        cyc();
        reset = 1'b0; active = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: busy=%b done=%b, want 0 0", busy, done);
        end
        arm(8'h05, 4'd0, 4'd0);
        fire();
        n_tests++;
        if (out_wr_en !== 16'h0001 || out_addr !== 128'h05) begin
            n_fail++;
            $display("FAIL restart_write: en=%h addr=%h, want 0001 ..05", out_wr_en, out_addr);
        end
        cyc();
        n_tests++;
        if (done !== 1'b1 || out_wr_en !== 16'h0) begin
            n_fail++;
            $display("FAIL restart_done: done=%b en=%h, want 1 0000", done, out_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_single();
        test_wrap();
        test_max();
        test_ignore();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
